div_stream_adapter: RTL and testbench



---
 rtl/div_stream_adapter_if.sv | 34 +++
 rtl/div_stream_adapter.sv | 106 ++++++++++
 tb/tb_div_stream_adapter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_stream_adapter_if.sv
// Bundles the request stream, divider issue/return and result stream of div_stream_adapter.
// The slave modport is the adapter's view; master is the surrounding producer/divider/consumer.
interface div_stream_adapter_if #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 24
);
    logic                      s_valid;
    logic                      s_ready;
    logic [DIVIDEND_WIDTH-1:0] s_dividend;
    logic [DIVISOR_WIDTH-1:0]  s_divisor;
    logic                      div_ivalid;
    logic [DIVIDEND_WIDTH-1:0] div_dividend;
    logic [DIVISOR_WIDTH-1:0]  div_divisor;
    logic                      div_ovalid;
    logic [DIVIDEND_WIDTH-1:0] div_quotient;
    logic                      m_valid;
    logic                      m_ready;
    logic [DIVIDEND_WIDTH-1:0] m_quotient;
    logic                      m_dbz;
    logic                      err_overflow;
    logic                      err_align;

    modport slave (
        input  s_valid, s_dividend, s_divisor, div_ovalid, div_quotient, m_ready,
        output s_ready, div_ivalid, div_dividend, div_divisor,
               m_valid, m_quotient, m_dbz, err_overflow, err_align
    );

    modport master (
        output s_valid, s_dividend, s_divisor, div_ovalid, div_quotient, m_ready,
        input  s_ready, div_ivalid, div_dividend, div_divisor,
               m_valid, m_quotient, m_dbz, err_overflow, err_align
    );
endinterface

// File: rtl/div_stream_adapter.sv
// Ready/valid wrapper around a fixed-latency divider: credit-gated issue, sideband
// divide-by-zero tagging, and a first-word-fall-through result FIFO.
module div_stream_adapter #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 24,
    parameter int PIPE_LATENCY   = 34,
    parameter int DEPTH          = 8
) (
    input logic                 sys_clk,
    input logic                 sys_rst,
    div_stream_adapter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DIVIDEND_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_CNT = DEPTH[CW-1:0];
    localparam logic [CW:0]   DEPTH_SUM = DEPTH[CW:0];
    localparam logic [DIVIDEND_WIDTH-1:0] Q_MAX = {1'b0, {(DIVIDEND_WIDTH-1){1'b1}}};
    localparam logic [DIVIDEND_WIDTH-1:0] Q_MIN = {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};

    logic [CW-1:0] inflight_q, inflight_d, count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    // sideband entry: {tag_valid, dbz, dividend_sign}
    logic [PIPE_LATENCY-1:0][2:0] sb_q, sb_d;
    logic err_overflow_q, err_overflow_d, err_align_q, err_align_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic          issue, push, pop, full, push_ok, dec;
    logic [2:0]    tap;
    logic [EW-1:0] push_data, head;
    logic [CW:0]   credit_used;

    // Credit uses registered state only, so a same-cycle pop frees a slot one cycle later.
    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign bus.s_ready = !sys_rst && (credit_used < DEPTH_SUM);

    assign issue            = bus.s_valid & bus.s_ready;
    assign bus.div_ivalid   = issue;
    assign bus.div_dividend = bus.s_dividend;
    assign bus.div_divisor  = bus.s_divisor;

    assign tap     = sb_q[PIPE_LATENCY-1];
    assign push    = bus.div_ovalid;
    assign full    = (count_q == DEPTH_CNT);
    assign pop     = bus.m_valid & bus.m_ready;
    assign push_ok = push & (!full | pop);
    assign dec     = push && (inflight_q != '0);

    always_comb begin
        push_data = {bus.div_quotient, 1'b0};
        if (tap[1]) push_data = {(tap[0] ? Q_MIN : Q_MAX), 1'b1};
    end

    assign head             = mem_q[rd_ptr_q];
    assign bus.m_valid      = (count_q != '0);
    assign bus.m_quotient   = bus.m_valid ? head[EW-1:1] : '0;
    assign bus.m_dbz        = bus.m_valid & head[0];
    assign bus.err_overflow = err_overflow_q;
    assign bus.err_align    = err_align_q;

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, dec})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        sb_d[0] = {issue, (bus.s_divisor == '0), bus.s_dividend[DIVIDEND_WIDTH-1]};
        for (int i = 1; i < PIPE_LATENCY; i++) sb_d[i] = sb_q[i-1];
        err_overflow_d = err_overflow_q | (push & full & !pop);
        err_align_d    = err_align_q | (tap[2] != push);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            inflight_q     <= '0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            sb_q           <= '0;
            err_overflow_q <= 1'b0;
            err_align_q    <= 1'b0;
        end else begin
            inflight_q     <= inflight_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            sb_q           <= sb_d;
            err_overflow_q <= err_overflow_d;
            err_align_q    <= err_align_d;
        end
    end

    // Storage needs no reset: outputs are gated by count.
    always_ff @(posedge sys_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: tb/tb_div_stream_adapter.sv
// Bench for div_stream_adapter: fixed-latency divider model plus an in-order scoreboard.
module tb_div_stream_adapter;
    localparam int L = 34;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_stream_adapter_if #(.DIVIDEND_WIDTH(32), .DIVISOR_WIDTH(24)) bus ();

    div_stream_adapter #(
        .DIVIDEND_WIDTH(32), .DIVISOR_WIDTH(24), .PIPE_LATENCY(L), .DEPTH(8)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q = '0;
    logic        exp_dbz = 1'b0;
    logic [32:0] sb_q[$];
    logic [32:0] mon_e;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [23:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = {{8{b[23]}}, b};
        if (sb == 0) return a[31] ? {32'h8000_0000, 1'b1} : {32'h7FFF_FFFF, 1'b1};
        return {32'(sa / sb), 1'b0};
    endfunction

    // divider model: quotient appears exactly L cycles after issue, garbage on zero divisor
    logic signed [31:0] md_dvs, md_q;
    logic [L-1:0]       md_v;
    logic [L-1:0][31:0] md_p;
    always_comb begin
        md_dvs = {{8{bus.div_divisor[23]}}, bus.div_divisor};
        md_q   = 32'hDEAD_BEEF;
        if (md_dvs != 0) md_q = $signed(bus.div_dividend) / md_dvs;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_v <= '0;
            md_p <= '0;
        end else begin
            md_v <= {md_v[L-2:0], bus.div_ivalid};
            md_p <= {md_p[L-2:0], md_q};
        end
    end
    assign bus.div_ovalid   = md_v[L-1];
    assign bus.div_quotient = md_p[L-1];

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) sb_q.delete();
        else begin
            if (bus.m_valid && bus.m_ready) begin
                if (sb_q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    mon_e = sb_q.pop_front();
                    chk("quot", bus.m_quotient, mon_e[32:1]);
                    chk("dbz", bus.m_dbz, mon_e[0]);
                end
            end
            if (bus.s_valid && bus.s_ready) sb_q.push_back({exp_q, exp_dbz});
            chk("credit_le_depth", sb_q.size() <= 8, 1);
        end
    end

    task automatic send(input logic [31:0] a, input logic [23:0] b,
                        input logic [31:0] eq, input logic ed);
        int n = 0;
        bus.s_valid = 1'b1; bus.s_dividend = a; bus.s_divisor = b;
        exp_q = eq; exp_dbz = ed;
        do begin @(negedge clk); n++; end while (!bus.s_ready && n < 200);
        if (!bus.s_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus.m_ready = 1'b1;
        while (sb_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk(tag, sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_err(input string tag);
        chk({tag, "_ovf"}, bus.err_overflow, 0);
        chk({tag, "_align"}, bus.err_align, 0);
    endtask

    initial begin
        int n, acc;
        logic acc_now;
        logic [32:0] r;
        bus.s_valid = 1'b0; bus.s_dividend = '0; bus.s_divisor = '0; bus.m_ready = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_quot", bus.m_quotient, 0);
        chk("rst_m_dbz", bus.m_dbz, 0);
        chk("rst_ivalid", bus.div_ivalid, 0);
        chk_err("rst");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", bus.s_ready, 1);

        // single request with latency check
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        send(32'd100, 24'd7, 32'd14, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.m_valid && n < 100);
        chk("latency", n, L + 1);
        @(negedge clk);
        chk("one_cycle_valid", bus.m_valid, 0);
        @(posedge clk); #1;

        // signed operands
        send(-32'sd100, 24'sd7, -32'sd14, 1'b0);
        send(32'sd100, -24'sd7, -32'sd14, 1'b0);
        send(-32'sd100, -24'sd7, 32'sd14, 1'b0);
        drain("drain_signed");
        chk_err("signed");

        // divide by zero
        send(32'sd5, 24'd0, 32'h7FFF_FFFF, 1'b1);
        send(-32'sd5, 24'd0, 32'h8000_0000, 1'b1);
        drain("drain_dbz");

        // backpressure
        bus.m_ready = 1'b0;
        acc = 0;
        bus.s_valid = 1'b1; bus.s_dividend = 32'd200; bus.s_divisor = 24'd1;
        exp_q = 32'd200; exp_dbz = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc_now = bus.s_ready;
            if (acc_now) acc++;
            @(posedge clk); #1;
            if (acc_now) begin
                bus.s_dividend = bus.s_dividend + 1;
                exp_q = bus.s_dividend;
            end
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted", acc, 8);
        chk("bp_s_ready_low", bus.s_ready, 0);
        chk("bp_m_valid", bus.m_valid, 1);
        chk("bp_ovf", bus.err_overflow, 0);
        @(posedge clk); #1 bus.m_ready = 1'b1;
        @(negedge clk);
        chk("pop_not_same_cycle", bus.s_ready, 0);
        @(posedge clk); #1 bus.m_ready = 1'b0;
        @(negedge clk);
        chk("pop_credit_next", bus.s_ready, 1);
        @(posedge clk); #1;
        drain("drain_bp");
        chk_err("bp");

        // random stress
        for (int c = 0; c < 10000; c++) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.m_ready = ($urandom_range(0, 3) != 0);
            bus.s_dividend = $urandom;
            if (bus.s_dividend == 32'h8000_0000) bus.s_dividend = '0;
            bus.s_divisor = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom);
            if ($urandom_range(0, 1) == 1) bus.s_divisor = 24'($signed(bus.s_divisor) >>> 16);
            r = ref_div(bus.s_dividend, bus.s_divisor);
            exp_q = r[32:1]; exp_dbz = r[0];
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        drain("drain_rand");
        chk_err("rand");

        // reset mid-operation: 2 results in FIFO, 3 in flight
        bus.m_ready = 1'b0;
        send(32'd11, 24'd1, 32'd11, 1'b0);
        send(32'd12, 24'd1, 32'd12, 1'b0);
        repeat (L + 2) @(posedge clk);
        #1;
        send(32'd13, 24'd1, 32'd13, 1'b0);
        send(32'd14, 24'd1, 32'd14, 1'b0);
        send(32'd15, 24'd1, 32'd15, 1'b0);
        @(negedge clk);
        chk("pre_rst_m_valid", bus.m_valid, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", bus.m_valid, 0);
        chk("mid_rst_s_ready", bus.s_ready, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_s_ready", bus.s_ready, 1);
        chk("rel_m_valid", bus.m_valid, 0);
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        send(32'd9, 24'd3, 32'd3, 1'b0);
        drain("drain_after_rst");
        chk_err("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
